trig_source_arbiter: RTL and testbench

//  Parametrised trigger-source combiner for the TURF trigger path: N level/pulse sources (soft, ext, PPS1, PPS2, ...)
//  -> single accepted-trigger pulse into TRIGGER_INTERFACE. Generalises soft_or_ext_pipe: per-source enable,

---
 rtl/trig_src_pkg.sv | 15 +
 rtl/trig_sat_counter.sv | 19 +
 rtl/trig_source_arbiter.sv | 125 ++++++++++++
 tb/tb_trig_source_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/trig_src_pkg.sv
// Shared definitions for the trigger-source arbiter: source slot indices
// and the arbiter FSM encoding.
package trig_src_pkg;

  localparam int SRC_SOFT = 0;
  localparam int SRC_EXT  = 1;
  localparam int SRC_PPS1 = 2;
  localparam int SRC_PPS2 = 3;

  typedef enum logic {
    ST_ARMED   = 1'b0,
    ST_HOLDOFF = 1'b1
  } trig_state_e;

endpackage

// File: rtl/trig_sat_counter.sv
// Saturating event scaler: counts inc pulses, sticks at all-ones,
// synchronous clear takes priority over a coincident increment.
module trig_sat_counter #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               clr,
  output logic [COUNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       cnt <= '0;
    else if (clr)                  cnt <= '0;
    else if (inc && (cnt != '1))   cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/trig_source_arbiter.sv
// Combines NUM_SRC synchronous trigger sources into one accepted-trigger
// pulse with enables, global disable, runtime deadtime and per-source scalers.
module trig_source_arbiter
  import trig_src_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int SEL_W     = 3,
  parameter int COUNT_W   = 32,
  parameter int HOLDOFF_W = 16
) (
  input  logic                 clk250_i,
  input  logic                 rst_i,
  input  logic [NUM_SRC-1:0]   src_i,
  input  logic [NUM_SRC-1:0]   en_i,
  input  logic                 disable_i,
  input  logic [HOLDOFF_W-1:0] holdoff_i,
  input  logic                 cnt_clr_i,
  input  logic [SEL_W-1:0]     cnt_sel_i,
  output logic                 trig_o,
  output logic [NUM_SRC-1:0]   trig_src_o,
  output logic [SEL_W-1:0]     trig_idx_o,
  output logic                 busy_o,
  output logic [COUNT_W-1:0]   cnt_o
);

  function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_SRC-1:0] v);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (v[i]) r = SEL_W'(i);
    return r;
  endfunction

  logic [NUM_SRC-1:0] src_q1, src_q2, edge_det, req;
  logic               any_req, accept, veto;
  trig_state_e        state_q, state_d;
  logic [HOLDOFF_W-1:0] hcnt_q;
  logic [NUM_SRC:0][COUNT_W-1:0] scaler;
  logic [NUM_SRC:0]   sc_inc;

  // Pipe resets to all-ones so a level already high at release is not an edge.
  always_ff @(posedge clk250_i or posedge rst_i) begin
    if (rst_i) begin
      src_q1 <= '1;
      src_q2 <= '1;
    end else begin
      src_q1 <= src_i;
      src_q2 <= src_q1;
    end
  end

  assign edge_det = src_q1 & ~src_q2;
  assign req      = edge_det & en_i;
  assign any_req  = |req;

  always_ff @(posedge clk250_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_ARMED;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARMED:   if (accept && (holdoff_i != '0)) state_d = ST_HOLDOFF;
      ST_HOLDOFF: if (hcnt_q <= HOLDOFF_W'(1))     state_d = ST_ARMED;
      default:    state_d = ST_ARMED;
    endcase
  end

  always_comb begin
    accept = 1'b0;
    veto   = 1'b0;
    busy_o = 1'b0;
    case (state_q)
      ST_ARMED: begin
        accept = any_req && !disable_i;
        veto   = any_req &&  disable_i;
      end
      ST_HOLDOFF: begin
        busy_o = 1'b1;
        veto   = any_req;
      end
      default: ;
    endcase
  end

  // Deadtime length is latched at accept; later holdoff_i changes are ignored.
  always_ff @(posedge clk250_i or posedge rst_i) begin
    if (rst_i) begin
      hcnt_q     <= '0;
      trig_o     <= 1'b0;
      trig_src_o <= '0;
      trig_idx_o <= '0;
    end else begin
      trig_o <= accept;
      if (accept) begin
        hcnt_q     <= holdoff_i;
        trig_src_o <= req;
        trig_idx_o <= lowest_set(req);
      end else if (state_q == ST_HOLDOFF) begin
        hcnt_q <= hcnt_q - 1'b1;
      end
    end
  end

  // Slots 0..NUM_SRC-1 count accepts per source; slot NUM_SRC counts vetoes.
  assign sc_inc = {veto, req & {NUM_SRC{accept}}};

  for (genvar g = 0; g <= NUM_SRC; g++) begin : g_scaler
    trig_sat_counter #(.COUNT_W(COUNT_W)) u_cnt (
      .clk (clk250_i),
      .rst (rst_i),
      .inc (sc_inc[g]),
      .clr (cnt_clr_i),
      .cnt (scaler[g])
    );
  end

  always_ff @(posedge clk250_i or posedge rst_i) begin
    if (rst_i)                          cnt_o <= '0;
    else if (int'(cnt_sel_i) <= NUM_SRC) cnt_o <= scaler[cnt_sel_i];
    else                                cnt_o <= '0;
  end

endmodule

// File: tb/tb_trig_source_arbiter.sv
// Scoreboard bench for trig_source_arbiter: expected triggers are queued at
// stimulus time and matched (cycle, mask, index) when trig_o fires.
module tb_trig_source_arbiter;

  localparam int NUM_SRC = 4;
  localparam int SEL_W   = 3;
  localparam int COUNT_W = 4;
  localparam int HOLDOFF_W = 16;

  logic                 clk250_i = 1'b0;
  logic                 rst_i;
  logic [NUM_SRC-1:0]   src_i, en_i;
  logic                 disable_i, cnt_clr_i;
  logic [HOLDOFF_W-1:0] holdoff_i;
  logic [SEL_W-1:0]     cnt_sel_i;
  logic                 trig_o, busy_o;
  logic [NUM_SRC-1:0]   trig_src_o;
  logic [SEL_W-1:0]     trig_idx_o;
  logic [COUNT_W-1:0]   cnt_o;

  trig_source_arbiter #(
    .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .COUNT_W(COUNT_W), .HOLDOFF_W(HOLDOFF_W)
  ) dut (
    .clk250_i(clk250_i), .rst_i(rst_i), .src_i(src_i), .en_i(en_i),
    .disable_i(disable_i), .holdoff_i(holdoff_i), .cnt_clr_i(cnt_clr_i),
    .cnt_sel_i(cnt_sel_i), .trig_o(trig_o), .trig_src_o(trig_src_o),
    .trig_idx_o(trig_idx_o), .busy_o(busy_o), .cnt_o(cnt_o)
  );

  always #2 clk250_i = ~clk250_i;

  typedef struct {
    int               cyc;
    logic [NUM_SRC-1:0] src;
    logic [SEL_W-1:0] idx;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  always @(posedge clk250_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Trigger monitor: every trig_o must match the oldest expectation.
  always @(negedge clk250_i) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      chk("trig_missing_cyc", cyc, e.cyc);
    end
    if (trig_o) begin
      if (sb.size() == 0) chk("trig_unexpected", trig_o, 1'b0);
      else begin
        e = sb.pop_front();
        chk("trig_cyc", cyc, e.cyc);
        chk("trig_src", trig_src_o, e.src);
        chk("trig_idx", trig_idx_o, e.idx);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk250_i);
  endtask

  task automatic pulse(input logic [NUM_SRC-1:0] m, input bit exp, input logic [SEL_W-1:0] idx);
    src_i = m;
    if (exp) sb.push_back('{cyc + 2, m, idx});
    @(negedge clk250_i);
    src_i = '0;
    @(negedge clk250_i);
  endtask

  task automatic rd(input string tag, input logic [SEL_W-1:0] sel, input logic [COUNT_W-1:0] exp);
    cnt_sel_i = sel;
    @(negedge clk250_i);
    chk(tag, cnt_o, exp);
  endtask

  initial begin
    int c0;
    rst_i = 1'b1; src_i = 4'b0010; en_i = 4'b1111; disable_i = 1'b0;
    holdoff_i = '0; cnt_clr_i = 1'b0; cnt_sel_i = '0;
    step(3);
    chk("rst_trig", trig_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_cnt", cnt_o, 0);
    // src[1] held high across reset release must not trigger
    rst_i = 1'b0;
    step(5);
    src_i = '0;
    step(3);
    chk("rst_src_held", trig_src_o, 4'b0000);
    chk("rst_idx", trig_idx_o, 0);

    // single source, zero holdoff
    pulse(4'b0010, 1, 3'd1);
    step(2);
    rd("t1_sc1", 3'd1, 1);
    chk("t1_busy", busy_o, 1'b0);

    // simultaneous edges
    pulse(4'b0101, 1, 3'd0);
    step(2);
    rd("t2_sc0", 3'd0, 1);
    rd("t2_sc2", 3'd2, 1);
    rd("t2_sel_oob", 3'd7, 0);

    // holdoff 10: veto inside deadtime, accept on first armed cycle
    holdoff_i = 16'd10;
    c0 = cyc;
    src_i = 4'b0001;
    sb.push_back('{c0 + 2, 4'b0001, 3'd0});
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk250_i);
      chk($sformatf("t3_busy_k%0d", k), busy_o, (k >= 2 && k <= 11));
      if (k == 5) src_i = 4'b1000;
      else if (k == 11) begin
        src_i = 4'b1000;
        holdoff_i = '0;
        sb.push_back('{cyc + 2, 4'b1000, 3'd3});
      end else src_i = '0;
    end
    step(2);
    rd("t3_veto", 3'd4, 1);
    rd("t3_sc3", 3'd3, 1);

    // global disable vetoes; disabled source ignored entirely
    disable_i = 1'b1;
    repeat (3) pulse(4'b0001, 0, 3'd0);
    disable_i = 1'b0;
    step(2);
    rd("t4_veto3", 3'd4, 4);
    en_i = 4'b1011;
    pulse(4'b0100, 0, 3'd0);
    step(2);
    rd("t4_veto_en", 3'd4, 4);
    rd("t4_sc2", 3'd2, 1);
    en_i = 4'b1111;

    // saturation, then clear coincident with accept
    repeat (20) pulse(4'b0010, 1, 3'd1);
    step(2);
    rd("t5_sat", 3'd1, 15);
    src_i = 4'b0010;
    sb.push_back('{cyc + 2, 4'b0010, 3'd1});
    @(negedge clk250_i);
    src_i = '0;
    cnt_clr_i = 1'b1;
    @(negedge clk250_i);
    cnt_clr_i = 1'b0;
    step(1);
    rd("t5_clr_sc1", 3'd1, 0);
    rd("t5_clr_sc0", 3'd0, 0);

    // reset mid-holdoff, then normal accept
    holdoff_i = 16'd20;
    pulse(4'b0001, 1, 3'd0);
    step(4);
    chk("t6_busy_pre", busy_o, 1'b1);
    #1 rst_i = 1'b1;
    #0.5;
    chk("t6_busy_async", busy_o, 1'b0);
    step(2);
    chk("t6_src_rst", trig_src_o, 4'b0000);
    rst_i = 1'b0;
    holdoff_i = '0;
    step(2);
    pulse(4'b1000, 1, 3'd3);
    step(3);
    rd("t6_sc3", 3'd3, 1);

    step(5);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
